alu: RTL and testbench

16-bit signed arithmetic/logic unit with a registered result and status flags. It executes one of 14 operations, selected by a 4-bit opcode, on two 16-bit two's-complement operands. The datapath of a simple processor uses it as the execute-stage unit. Operands and opcode are captured on every rising clock edge, and results appear one cycle later.

---
 rtl/alu_if.sv | 22 ++
 rtl/alu.sv | 139 +++++++++++++
 tb/tb_alu.sv | 125 ++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// Operand/result bundle between the datapath and the ALU.
// master drives a, b, opcode; slave drives result and flags.
interface alu_if;
   logic [15:0] a;
   logic [15:0] b;
   logic [3:0]  opcode;
   logic [15:0] result;
   logic        zero;
   logic        negative;
   logic        carryout;
   logic        overflow;

   modport master (
      output a, b, opcode,
      input  result, zero, negative, carryout, overflow
   );

   modport slave (
      input  a, b, opcode,
      output result, zero, negative, carryout, overflow
   );
endinterface

// File: rtl/alu.sv
// 16-bit signed ALU, one registered stage, 14 opcodes plus flags.
// Ports: clk, rst_n (async low), bus (alu_if.slave: a, b, opcode in; result, flags out).
module alu (
   input  logic   clk,
   input  logic   rst_n,
   alu_if.slave   bus
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_XOR  = 4'b0010;
   localparam logic [3:0] OP_NOR  = 4'b0011;
   localparam logic [3:0] OP_NAND = 4'b0100;
   localparam logic [3:0] OP_NOT  = 4'b0101;
   localparam logic [3:0] OP_ADD  = 4'b0110;
   localparam logic [3:0] OP_SUB  = 4'b0111;
   localparam logic [3:0] OP_SLT  = 4'b1000;
   localparam logic [3:0] OP_MULT = 4'b1001;
   localparam logic [3:0] OP_DIV  = 4'b1010;
   localparam logic [3:0] OP_MOD  = 4'b1011;
   localparam logic [3:0] OP_SLA  = 4'b1100;
   localparam logic [3:0] OP_SRA  = 4'b1101;

   logic signed [15:0] sa;
   logic signed [15:0] sb;
   logic signed [15:0] dsr;
   logic signed [31:0] prod;
   logic signed [15:0] quo;
   logic signed [15:0] rem;
   logic        [16:0] sum17;
   logic        [15:0] diff;
   logic               b_zero;
   logic               min_neg1;

   logic [15:0] r_nxt;
   logic        c_nxt;
   logic        v_nxt;

   logic [15:0] r_q;
   logic        z_q;
   logic        n_q;
   logic        c_q;
   logic        v_q;

   assign sa       = bus.a;
   assign sb       = bus.b;
   assign b_zero   = (bus.b == 16'h0000);
   assign min_neg1 = (bus.a == 16'h8000) && (bus.b == 16'hFFFF);

   // Substitute a harmless divisor so the divider never sees 0
   // or the one quotient that does not fit; those cases are
   // overridden below anyway.
   assign dsr  = (b_zero || min_neg1) ? 16'sd1 : sb;
   assign quo  = sa / dsr;
   assign rem  = sa % dsr;
   assign prod = sa * sb;

   assign sum17 = {1'b0, bus.a} + {1'b0, bus.b};
   assign diff  = bus.a - bus.b;

   always_comb begin
      r_nxt = 16'h0000;
      c_nxt = 1'b0;
      v_nxt = 1'b0;
      case (bus.opcode)
         OP_AND:  r_nxt = bus.a & bus.b;
         OP_OR:   r_nxt = bus.a | bus.b;
         OP_XOR:  r_nxt = bus.a ^ bus.b;
         OP_NOR:  r_nxt = ~(bus.a | bus.b);
         OP_NAND: r_nxt = ~(bus.a & bus.b);
         OP_NOT:  r_nxt = ~bus.a;
         OP_ADD: begin
            r_nxt = sum17[15:0];
            c_nxt = sum17[16];
            v_nxt = (bus.a[15] == bus.b[15]) &&
                    (sum17[15] != bus.a[15]);
         end
         OP_SUB: begin
            r_nxt = diff;
            c_nxt = (bus.a < bus.b);
            v_nxt = (bus.a[15] != bus.b[15]) &&
                    (diff[15] != bus.a[15]);
         end
         OP_SLT:  r_nxt = {15'd0, (sa < sb)};
         OP_MULT: begin
            r_nxt = prod[15:0];
            // Fits in 16 signed bits only if bits 31..15 agree.
            v_nxt = (prod[31:15] != {17{prod[15]}});
         end
         OP_DIV: begin
            if (b_zero) begin
               r_nxt = 16'h0000;
               v_nxt = 1'b1;
            end else if (min_neg1) begin
               r_nxt = 16'h8000;
               v_nxt = 1'b1;
            end else begin
               r_nxt = quo;
            end
         end
         OP_MOD: begin
            if (b_zero) begin
               r_nxt = bus.a;
               v_nxt = 1'b1;
            end else if (min_neg1) begin
               r_nxt = 16'h0000;
            end else begin
               r_nxt = rem;
            end
         end
         OP_SLA:  r_nxt = {bus.a[11:0], 4'b0000};
         OP_SRA:  r_nxt = {{4{bus.a[15]}}, bus.a[15:4]};
         default: r_nxt = 16'h0000;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= 16'h0000;
         z_q <= 1'b1;
         n_q <= 1'b0;
         c_q <= 1'b0;
         v_q <= 1'b0;
      end else begin
         r_q <= r_nxt;
         z_q <= (r_nxt == 16'h0000);
         n_q <= r_nxt[15];
         c_q <= c_nxt;
         v_q <= v_nxt;
      end
   end

   assign bus.result   = r_q;
   assign bus.zero     = z_q;
   assign bus.negative = n_q;
   assign bus.carryout = c_q;
   assign bus.overflow = v_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu.
// Checks result and flags packed as {result, z, n, c, v}.
module tb_alu;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   alu_if bus ();

   alu dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [19:0] outs();
      return {bus.result, bus.zero, bus.negative,
              bus.carryout, bus.overflow};
   endfunction

   task automatic chk(input string tag,
                      input logic [19:0] got,
                      input logic [19:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got r=%h znco=%b want r=%h znco=%b",
                  tag, got[19:4], got[3:0], exp[19:4], exp[3:0]);
      end
   endtask

   // Drive one operation, let one edge capture it, check 1 ns later.
   task automatic op(input string tag,
                     input logic [3:0]  opc,
                     input logic [15:0] a,
                     input logic [15:0] b,
                     input logic [15:0] r,
                     input logic [3:0]  f);
      bus.opcode = opc;
      bus.a      = a;
      bus.b      = b;
      @(posedge clk);
      #1;
      chk(tag, outs(), {r, f});
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus.a      = 16'h1234;
      bus.b      = 16'h5678;
      bus.opcode = 4'b0110;
      repeat (2) @(posedge clk);
      #1;
      chk("reset", outs(), {16'h0000, 4'b1000});

      rst_n = 1'b1;
      op("or_pre", 4'b0001, 16'd0, 16'd1, 16'd1, 4'b0000);

      // Async reset mid-cycle, no clock edge in between.
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst", outs(), {16'h0000, 4'b1000});
      #3;
      rst_n = 1'b1;

      op("and",    4'b0000, 16'd1,   16'd0,   16'h0000, 4'b1000);
      op("or",     4'b0001, 16'd0,   16'd1,   16'h0001, 4'b0000);
      op("xor",    4'b0010, 16'd1,   16'd1,   16'h0000, 4'b1000);
      op("nor",    4'b0011, 16'd1,   16'd0,   16'hFFFE, 4'b0100);
      op("nand",   4'b0100, 16'hFFCA, 16'hFFE0, 16'h003F, 4'b0000);
      op("not",    4'b0101, 16'd24,  16'd99,  16'hFFE7, 4'b0100);
      op("add_ov", 4'b0110, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
      op("add_c",  4'b0110, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010);
      op("sub",    4'b0111, 16'd5,   16'd4,   16'h0001, 4'b0000);
      op("sub_b",  4'b0111, 16'd4,   16'd5,   16'hFFFF, 4'b0110);
      op("sub_ov", 4'b0111, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001);
      op("slt",    4'b1000, 16'd3,   16'd10,  16'h0001, 4'b0000);
      op("slt_sg", 4'b1000, 16'hFFFF, 16'd1,  16'h0001, 4'b0000);
      op("slt_f",  4'b1000, 16'd1,   16'hFFFF, 16'h0000, 4'b1000);
      op("mult",   4'b1001, 16'd4,   16'd2,   16'h0008, 4'b0000);
      op("mult_ov",4'b1001, 16'd300, 16'd300, 16'h5F90, 4'b0001);
      op("mult_ng",4'b1001, 16'hFFFD, 16'd5,  16'hFFF1, 4'b0100);
      op("div",    4'b1010, 16'd10,  16'd5,   16'h0002, 4'b0000);
      op("div_neg",4'b1010, 16'hFFF9, 16'd2,  16'hFFFD, 4'b0100);
      op("mod",    4'b1011, 16'd4,   16'd3,   16'h0001, 4'b0000);
      op("mod_neg",4'b1011, 16'hFFF9, 16'd2,  16'hFFFF, 4'b0100);
      op("div_0",  4'b1010, 16'd7,   16'd0,   16'h0000, 4'b1001);
      op("div_min",4'b1010, 16'h8000, 16'hFFFF, 16'h8000, 4'b0101);
      op("mod_0",  4'b1011, 16'd7,   16'd0,   16'h0007, 4'b0001);
      op("mod_min",4'b1011, 16'h8000, 16'hFFFF, 16'h0000, 4'b1000);
      op("sla",    4'b1100, 16'hFFFE, 16'd77, 16'hFFE0, 4'b0100);
      op("sra_0",  4'b1101, 16'd8,   16'd0,   16'h0000, 4'b1000);
      op("sra_n",  4'b1101, 16'hFFE0, 16'd0,  16'hFFFE, 4'b0100);
      op("op_e",   4'b1110, 16'd10,  16'd10,  16'h0000, 4'b1000);
      op("op_f",   4'b1111, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000);

      // Inputs changing between edges must not reach the outputs.
      op("hold_a", 4'b0110, 16'd2, 16'd3, 16'h0005, 4'b0000);
      bus.a      = 16'd100;
      bus.opcode = 4'b0111;
      #3;
      chk("hold_b", outs(), {16'h0005, 4'b0000});
      @(posedge clk);
      #1;
      chk("hold_c", outs(), {16'h0061, 4'b0000});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule
